// File: rtl/motoro3_step_sequencer.sv
// Commutation step sequencer: 12 steps, each split into 1..4 timed sub-steps.
// Define M3_STEP_DIR_EN to let m3r_dir select reverse stepping.
module motoro3_step_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        m3r_enable,
    input  logic        m3r_dir,
    input  logic [24:0] m3r_stepCNT_speedSET,
    input  logic [1:0]  m3r_stepSplitMax,
    output logic [3:0]  lcStep,
    output logic [1:0]  m3LpwmSplitStep,
    output logic        m3StepTick,
    output logic        m3CycleTick,
    output logic        m3Running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t      state, state_nx;
    logic [24:0] cnt;
    logic [24:0] lspeed;
    logic [24:0] speed_clamped;
    logic [1:0]  lsplit;
    logic        active;
    logic        sub_end;
    logic        step_end;
    logic        wrap;
    logic [3:0]  step_nx;
    logic        rev;

    assign speed_clamped = (m3r_stepCNT_speedSET < 25'd2) ? 25'd2
                                                          : m3r_stepCNT_speedSET;
    assign active   = (state != IDLE);
    assign sub_end  = active && (cnt == lspeed - 25'd1);
    assign step_end = sub_end && (m3LpwmSplitStep == lsplit);

`ifdef M3_STEP_DIR_EN
    assign rev = m3r_dir;
`else
    logic unused_dir;
    assign unused_dir = m3r_dir;
    assign rev = 1'b0;
`endif

    // Out-of-range step values collapse to 0 without signalling a cycle wrap.
    always_comb begin
        step_nx = 4'd0;
        wrap    = 1'b0;
        unique case (1'b1)
            (lcStep > 4'd11): begin
                step_nx = 4'd0;
            end
            (rev && lcStep == 4'd0): begin
                step_nx = 4'd11;
                wrap    = 1'b1;
            end
            (rev && lcStep != 4'd0): begin
                step_nx = lcStep - 4'd1;
            end
            (!rev && lcStep == 4'd11): begin
                step_nx = 4'd0;
                wrap    = 1'b1;
            end
            default: begin
                step_nx = lcStep + 4'd1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (m3r_enable) state_nx = RUN;
            RUN:      if (!m3r_enable) state_nx = STOPPING;
            STOPPING: begin
                if (m3r_enable)    state_nx = RUN;
                else if (step_end) state_nx = IDLE;
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= 25'd0;
            lcStep          <= 4'd0;
            m3LpwmSplitStep <= 2'd0;
            m3StepTick      <= 1'b0;
            m3CycleTick     <= 1'b0;
            m3Running       <= 1'b0;
            lspeed          <= 25'd2;
            lsplit          <= 2'd0;
        end else begin
            m3StepTick  <= 1'b0;
            m3CycleTick <= 1'b0;
            m3Running   <= (state_nx != IDLE);
            if (!active) begin
                if (m3r_enable) begin
                    cnt             <= 25'd0;
                    m3LpwmSplitStep <= 2'd0;
                    lspeed          <= speed_clamped;
                    lsplit          <= m3r_stepSplitMax;
                end
            end else if (sub_end) begin
                cnt    <= 25'd0;
                lspeed <= speed_clamped;
                if (step_end) begin
                    // Split count only changes between steps.
                    m3LpwmSplitStep <= 2'd0;
                    lsplit          <= m3r_stepSplitMax;
                    lcStep          <= step_nx;
                    m3StepTick      <= 1'b1;
                    m3CycleTick     <= wrap;
                end else begin
                    m3LpwmSplitStep <= m3LpwmSplitStep + 2'd1;
                end
            end else begin
                cnt <= cnt + 25'd1;
            end
        end
    end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Scoreboard bench for motoro3_step_sequencer: expected step ticks are
// queued by the stimulus and checked by a monitor on the falling edge.
module tb_motoro3_step_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m3r_enable = 1'b0;
    logic        m3r_dir = 1'b0;
    logic [24:0] m3r_stepCNT_speedSET = 25'd4;
    logic [1:0]  m3r_stepSplitMax = 2'd0;
    logic [3:0]  lcStep;
    logic [1:0]  m3LpwmSplitStep;
    logic        m3StepTick;
    logic        m3CycleTick;
    logic        m3Running;

    motoro3_step_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .m3r_enable           (m3r_enable),
        .m3r_dir              (m3r_dir),
        .m3r_stepCNT_speedSET (m3r_stepCNT_speedSET),
        .m3r_stepSplitMax     (m3r_stepSplitMax),
        .lcStep               (lcStep),
        .m3LpwmSplitStep      (m3LpwmSplitStep),
        .m3StepTick           (m3StepTick),
        .m3CycleTick          (m3CycleTick),
        .m3Running            (m3Running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] lc;
        logic       cyc;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_tick = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void push(input logic [3:0] lc, input logic c,
                                 input int gap);
        exp_t e;
        e.lc  = lc;
        e.cyc = c;
        e.gap = gap;
        q.push_back(e);
    endfunction

    // gap==0 marks the first tick after a start, whose distance is not checked
    always @(negedge clk) begin
        if (!rst && (m3StepTick || m3CycleTick)) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_tick: got lcStep=%0d cycle=%0b expected no tick",
                         lcStep, m3CycleTick);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tick_step", int'(m3StepTick), 1);
                chk("tick_lcStep", int'(lcStep), int'(e.lc));
                chk("tick_cycle", int'(m3CycleTick), int'(e.cyc));
                if (e.gap != 0) chk("tick_gap", cyc - last_tick, e.gap);
            end
            last_tick = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        m3r_enable = 1'b0;
        m3r_dir    = 1'b0;
        step();
        step();
    endtask

    task automatic wait_for(input logic [3:0] lc, input logic [1:0] sp,
                            input int budget, input string nm);
        int n = 0;
        while (!(lcStep == lc && m3LpwmSplitStep == sp) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!(lcStep == lc && m3LpwmSplitStep == sp)) begin
            fails++;
            $display("FAIL %s: got lcStep=%0d split=%0d expected %0d/%0d",
                     nm, lcStep, m3LpwmSplitStep, lc, sp);
        end
    endtask

    task automatic drain(input int budget, input string nm);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(nm, q.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_lcStep"}, int'(lcStep), 0);
        chk({nm, "_split"}, int'(m3LpwmSplitStep), 0);
        chk({nm, "_stepTick"}, int'(m3StepTick), 0);
        chk({nm, "_cycleTick"}, int'(m3CycleTick), 0);
        chk({nm, "_running"}, int'(m3Running), 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_zero("reset");

        // Basic stepping: 4 clocks per step, wrap 11->0
        m3r_stepCNT_speedSET = 25'd4;
        m3r_stepSplitMax     = 2'd0;
        for (int i = 1; i <= 12; i++)
            push(4'(i % 12), i == 12, (i == 1) ? 0 : 4);
        rst        = 1'b0;
        m3r_enable = 1'b1;
        drain(100, "basic_drain");

        // Sub-stepping, mid-step split change, graceful stop
        do_reset();
        m3r_stepCNT_speedSET = 25'd3;
        m3r_stepSplitMax     = 2'd3;
        push(4'd1, 1'b0, 0);
        push(4'd2, 1'b0, 12);
        push(4'd3, 1'b0, 6);
        push(4'd4, 1'b0, 6);
        push(4'd5, 1'b0, 12);
        push(4'd6, 1'b0, 12);
        rst        = 1'b0;
        m3r_enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("substep_seq", int'(m3LpwmSplitStep), i / 3);
        end
        wait_for(4'd1, 2'd1, 40, "reach_1_1");
        m3r_stepSplitMax = 2'd1;
        wait_for(4'd3, 2'd0, 40, "reach_3_0");
        m3r_stepSplitMax = 2'd3;
        wait_for(4'd5, 2'd1, 60, "reach_5_1");
        m3r_enable = 1'b0;
        step();
        chk("stopping_running", int'(m3Running), 1);
        drain(40, "stop_drain");
        repeat (4) step();
        chk("stop_running", int'(m3Running), 0);
        chk("stop_lcStep", int'(lcStep), 6);
        chk("stop_split", int'(m3LpwmSplitStep), 0);

        // Clamp speed 0 -> 2 clocks, then reset mid-step
        do_reset();
        m3r_stepCNT_speedSET = 25'd0;
        m3r_stepSplitMax     = 2'd0;
        push(4'd1, 1'b0, 0);
        push(4'd2, 1'b0, 2);
        push(4'd3, 1'b0, 2);
        push(4'd4, 1'b0, 2);
        rst        = 1'b0;
        m3r_enable = 1'b1;
        wait_for(4'd4, 2'd0, 40, "clamp_reach_4");
        step();
        rst = 1'b1;
        #1;
        chk_zero("midstep_reset");
        chk("clamp_queue", q.size(), 0);

        // Direction
        do_reset();
        m3r_stepCNT_speedSET = 25'd4;
        m3r_stepSplitMax     = 2'd0;
        push(4'd1, 1'b0, 0);
`ifdef M3_STEP_DIR_EN
        push(4'd0, 1'b0, 4);
        push(4'd11, 1'b1, 4);
        push(4'd10, 1'b0, 4);
`else
        push(4'd2, 1'b0, 4);
        push(4'd3, 1'b0, 4);
        push(4'd4, 1'b0, 4);
`endif
        rst        = 1'b0;
        m3r_enable = 1'b1;
        wait_for(4'd1, 2'd0, 20, "dir_reach_1");
        m3r_dir = 1'b1;
`ifdef M3_STEP_DIR_EN
        wait_for(4'd11, 2'd0, 20, "dir_reach_end");
`else
        wait_for(4'd3, 2'd0, 20, "dir_reach_end");
`endif
        m3r_enable = 1'b0;
        drain(20, "dir_drain");
        repeat (3) step();
        chk("dir_running", int'(m3Running), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
